sv_fetch_stream: RTL and testbench

Parametrised support-vector fetch engine. On `start` it reads `num_words` consecutive words from the support-vector block RAM, beginning at `base_addr`. Each word is `LANES` pixels wide. It presents the words as a valid/ready stream to the SVM dot-product datapath. It honours the memory-stage stall `stall_MEM`, absorbs downstream backpressure across the 1-cycle RAM read latency through a 2-entry buffer, and supports abort. The block RAM is external; this block drives its read port.

---
 rtl/sv_fetch_stream.sv | 219 +++++++++++++++++++++
 tb/tb_sv_fetch_stream.sv | 591 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_fetch_stream.sv
// sv_fetch_stream: support-vector fetch engine.
//
// On start, reads num_words consecutive words from an external block RAM,
// beginning at base_addr. The read data is presented to the SVM dot-product
// datapath as a valid/ready stream. A 2-entry buffer absorbs consumer
// backpressure across the 1-cycle RAM read latency.
//
// Optional feature: define SV_FETCH_LOOP_EN to add the loop_mode input. When
// loop_mode is latched high, the engine re-reads the window continuously
// until it is aborted.
//
// Stream handshake: a beat transfers on every rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low,
// out_data and out_last hold their values and out_valid stays high. out_valid
// never depends combinationally on out_ready.
module sv_fetch_stream #(
    parameter int XLEN_PIXEL = 8,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDR_WIDTH-1:0]       base_addr,
    input  logic [ADDR_WIDTH:0]         num_words,
    input  logic                        stall_MEM,
`ifdef SV_FETCH_LOOP_EN
    input  logic                        loop_mode,
`endif
    output logic                        mem_re,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    input  logic [LANES*XLEN_PIXEL-1:0] mem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*XLEN_PIXEL-1:0] out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  dbg_state
);

    localparam int DW = LANES * XLEN_PIXEL;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   done_q;
    logic   done_d;

    // Pass parameters captured when a pass is accepted
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   num_q;
    logic [ADDR_WIDTH:0]   issued_q;
    logic                  loop_q;
    logic                  loop_in;

    // Read that was issued last cycle and whose data is on mem_rdata now
    logic inflight_q;
    logic inflight_last_q;

    // Two-entry output buffer
    logic [DW-1:0] fifo_data [2];
    logic [1:0]    fifo_last;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    occ_q;

    logic active;
    logic accept_start;
    logic flush;
    logic push;
    logic pop;
    logic last_issue;
    logic issue_room;

`ifdef SV_FETCH_LOOP_EN
    assign loop_in = loop_mode;
`else
    assign loop_in = 1'b0;
`endif

    assign active       = (state_q != S_IDLE);
    assign accept_start = (state_q == S_IDLE) && start && !abort && (num_words != '0);
    assign flush        = active && abort;
    assign push         = inflight_q;
    assign pop          = out_valid && out_ready;
    assign last_issue   = (issued_q == (num_q - CNT_ONE));

    // Room check counts the buffered beats plus the read landing this cycle,
    // minus the beat leaving this cycle, so the buffer can never overflow.
    assign issue_room = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    // Issue a read while fetching, not stalled, words remain and there is room
    assign mem_re   = (state_q == S_FETCH) && !abort && !stall_MEM &&
                      (issued_q < num_q) && issue_room;
    assign mem_addr = base_q + issued_q[ADDR_WIDTH-1:0];

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = out_valid ? fifo_data[rd_ptr_q] : '0;
    assign out_last  = out_valid && fifo_last[rd_ptr_q];
    assign busy      = active;
    assign done      = done_q;
    assign dbg_state = state_q;

    // State and completion-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic and completion pulse request
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A zero-length pass completes immediately without any reads
                if (start && !abort) begin
                    if (num_words != '0) begin
                        state_d = S_FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (mem_re && last_issue && !loop_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last beat leaving means nothing is buffered or in flight
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (pop && out_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pass parameters, issue counter and in-flight tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q          <= '0;
            num_q           <= '0;
            issued_q        <= '0;
            loop_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            // mem_re is already low on abort, so an abort also clears this
            inflight_q <= mem_re;
            if (mem_re) begin
                inflight_last_q <= last_issue;
            end
            if (accept_start) begin
                base_q   <= base_addr;
                num_q    <= num_words;
                issued_q <= '0;
                loop_q   <= loop_in;
            end else if (mem_re) begin
                // In loop mode the window restarts right after its last word
                if (loop_q && last_issue) begin
                    issued_q <= '0;
                end else begin
                    issued_q <= issued_q + CNT_ONE;
                end
            end
        end
    end

    // Output buffer: push landed read data, pop accepted beats, flush on abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            occ_q        <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr_q] <= mem_rdata;
                fifo_last[wr_ptr_q] <= inflight_last_q;
                wr_ptr_q            <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sv_fetch_stream.sv
// Directed testbench for sv_fetch_stream. The RAM model returns the word
// address, zero-extended, as the word data.
module tb_sv_fetch_stream;

    localparam int XLEN_PIXEL = 8;
    localparam int LANES      = 4;
    localparam int ADDR_WIDTH = 10;
    localparam int DW         = XLEN_PIXEL * LANES;

    // Clock / reset and DUT signals
    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  start     = 1'b0;
    logic                  abort     = 1'b0;
    logic                  stall_MEM = 1'b0;
    logic                  out_ready = 1'b0;
    logic [ADDR_WIDTH-1:0] base_addr = '0;
    logic [ADDR_WIDTH:0]   num_words = '0;
`ifdef SV_FETCH_LOOP_EN
    logic                  loop_mode = 1'b0;
`endif
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DW-1:0]         mem_rdata = '0;
    logic                  out_valid;
    logic [DW-1:0]         out_data;
    logic                  out_last;
    logic                  busy;
    logic                  done;
    logic [1:0]            dbg_state;

    // Scoreboard state
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic          got_last_q[$];
    int            got_cyc_q[$];
    logic [ADDR_WIDTH-1:0] addr_q[$];
    int            re_cnt        = 0;
    int            valid_cnt     = 0;
    int            done_cnt      = 0;
    int            done_cyc      = 0;
    int            done_busy_err = 0;
    int            hold_err      = 0;
    int            occ_err       = 0;
    int            occ_m         = 0;
    logic          prev_hold     = 1'b0;
    logic          prev_re       = 1'b0;
    logic [DW-1:0] prev_data     = '0;
    logic          hold_chk_en   = 1'b0;
    logic          occ_chk_en    = 1'b0;

    sv_fetch_stream #(
        .XLEN_PIXEL(XLEN_PIXEL),
        .LANES     (LANES),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .base_addr(base_addr),
        .num_words(num_words),
        .stall_MEM(stall_MEM),
`ifdef SV_FETCH_LOOP_EN
        .loop_mode(loop_mode),
`endif
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Block RAM model: 1-cycle read latency, word data = address
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= {{(DW-ADDR_WIDTH){1'b0}}, mem_addr};
    end

    // Monitor: sampled mid-cycle, records accepted beats and protocol errors
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
                got_cyc_q.push_back(cyc);
            end
            if (mem_re) begin
                re_cnt++;
                addr_q.push_back(mem_addr);
            end
            if (out_valid) valid_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) done_busy_err++;
            end
            if (hold_chk_en) begin
                if (prev_hold && (!out_valid || out_data !== prev_data)) hold_err++;
                prev_hold = out_valid && !out_ready;
                prev_data = out_data;
            end else begin
                prev_hold = 1'b0;
            end
            if (occ_chk_en) begin
                if (occ_m > 2 || out_valid !== (occ_m != 0)) occ_err++;
                occ_m   = occ_m + (prev_re ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
                prev_re = mem_re;
            end else begin
                occ_m   = 0;
                prev_re = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({mem_re, mem_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: mem_re=%0b addr=%h valid=%0b data=%h last=%0b busy=%0b done=%0b, expected all 0",
                     mem_re, mem_addr, out_valid, out_data, out_last, busy, done);
        end
        checks++;
        if (dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d expected 0", dbg_state);
        end
        step();
        rst_n = 1'b1;
        step();
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || mem_re !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%0b valid=%0b mem_re=%0b expected 0 0 0", busy, out_valid, mem_re);
        end
    endtask

    task automatic test_basic();
        int g0;
        int d0;
        int c0;
        g0 = got_q.size();
        d0 = done_cnt;
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(DW'(32'h010 + i));
        step();
        base_addr = 10'h010;
        num_words = 11'd4;
        out_ready = 1'b1;
        start     = 1'b1;
        c0        = cyc;
        step();
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || mem_re !== 1'b1 || mem_addr !== 10'h010) begin
            failures++;
            $display("FAIL basic_first_issue: busy=%0b mem_re=%0b addr=%h expected 1 1 010", busy, mem_re, mem_addr);
        end
        for (int i = 0; i < 30 && done_cnt == d0; i++) step();
        step();
        step();
        checks++;
        if (got_q.size() - g0 != 4) begin
            failures++;
            $display("FAIL basic_beat_count: got %0d expected 4", got_q.size() - g0);
        end
        for (int i = 0; i < 4; i++) begin
            logic [DW:0] a;
            int          ac;
            a  = (g0 + i < got_q.size()) ? {got_last_q[g0 + i], got_q[g0 + i]} : 'x;
            ac = (g0 + i < got_cyc_q.size()) ? got_cyc_q[g0 + i] - c0 : -1;
            checks++;
            if (a !== {(i == 3), exp_q[i]} || ac != 3 + i) begin
                failures++;
                $display("FAIL basic_beat[%0d]: got last/data %h at cycle %0d expected %h at cycle %0d",
                         i, a, ac, {(i == 3), exp_q[i]}, 3 + i);
            end
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc - c0 != 7) begin
            failures++;
            $display("FAIL basic_done: got %0d pulses last at cycle %0d expected 1 at cycle 7", done_cnt - d0, done_cyc - c0);
        end
        checks++;
        if (done_busy_err != 0) begin
            failures++;
            $display("FAIL basic_busy_at_done: busy high with done %0d times expected 0", done_busy_err);
        end
    endtask

    task automatic test_wrap();
        int g0;
        int a0;
        int d0;
        logic [ADDR_WIDTH-1:0] exp_addr [4];
        exp_addr[0] = 10'h3FE;
        exp_addr[1] = 10'h3FF;
        exp_addr[2] = 10'h000;
        exp_addr[3] = 10'h001;
        g0 = got_q.size();
        a0 = addr_q.size();
        d0 = done_cnt;
        step();
        base_addr = 10'h3FE;
        num_words = 11'd4;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30 && done_cnt == d0; i++) step();
        step();
        for (int i = 0; i < 4; i++) begin
            logic [ADDR_WIDTH-1:0] ad;
            logic [DW-1:0]         da;
            ad = (a0 + i < addr_q.size()) ? addr_q[a0 + i] : 'x;
            da = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            checks++;
            if (ad !== exp_addr[i] || da !== {{(DW-ADDR_WIDTH){1'b0}}, exp_addr[i]}) begin
                failures++;
                $display("FAIL wrap[%0d]: got addr %h data %h expected addr %h data %h", i, ad, da, exp_addr[i], exp_addr[i]);
            end
        end
        checks++;
        if (addr_q.size() - a0 != 4 || got_q.size() - g0 != 4) begin
            failures++;
            $display("FAIL wrap_counts: got %0d reads %0d beats expected 4 4", addr_q.size() - a0, got_q.size() - g0);
        end
    endtask

    task automatic test_backpressure_stall();
        int g0;
        int d0;
        int h0;
        int o0;
        int k;
        g0 = got_q.size();
        d0 = done_cnt;
        h0 = hold_err;
        o0 = occ_err;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(DW'(32'h020 + i));
        step();
        hold_chk_en = 1'b1;
        occ_chk_en  = 1'b1;
        base_addr   = 10'h020;
        num_words   = 11'd8;
        out_ready   = 1'b1;
        start       = 1'b1;
        k           = 0;
        for (int i = 0; i < 100 && done_cnt == d0; i++) begin
            step();
            start     = 1'b0;
            k++;
            out_ready = ((k % 3) == 0);
            stall_MEM = (k >= 3 && k <= 5);
        end
        out_ready = 1'b1;
        stall_MEM = 1'b0;
        step();
        step();
        hold_chk_en = 1'b0;
        occ_chk_en  = 1'b0;
        checks++;
        if (got_q.size() - g0 != 8) begin
            failures++;
            $display("FAIL bp_beat_count: got %0d expected 8", got_q.size() - g0);
        end
        for (int i = 0; i < 8; i++) begin
            logic [DW:0] a;
            a = (g0 + i < got_q.size()) ? {got_last_q[g0 + i], got_q[g0 + i]} : 'x;
            checks++;
            if (a !== {(i == 7), exp_q[i]}) begin
                failures++;
                $display("FAIL bp_beat[%0d]: got last/data %h expected %h", i, a, {(i == 7), exp_q[i]});
            end
        end
        checks++;
        if (hold_err != h0) begin
            failures++;
            $display("FAIL bp_hold_stable: got %0d hold violations expected 0", hold_err - h0);
        end
        checks++;
        if (occ_err != o0) begin
            failures++;
            $display("FAIL bp_occupancy: got %0d occupancy violations expected 0", occ_err - o0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL bp_done: got %0d pulses expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_stall_timing();
        int g0;
        int d0;
        int c0;
        int k;
        int lc;
        g0 = got_q.size();
        d0 = done_cnt;
        step();
        base_addr = 10'h030;
        num_words = 11'd6;
        out_ready = 1'b1;
        start     = 1'b1;
        c0        = cyc;
        k         = 0;
        for (int i = 0; i < 40 && done_cnt == d0; i++) begin
            step();
            start     = 1'b0;
            k++;
            stall_MEM = (k >= 2 && k <= 4);
        end
        stall_MEM = 1'b0;
        step();
        lc = (got_cyc_q.size() > g0) ? got_cyc_q[got_cyc_q.size() - 1] - c0 : -1;
        checks++;
        if (got_q.size() - g0 != 6 || lc != 11) begin
            failures++;
            $display("FAIL stall_last_beat: got %0d beats last at cycle %0d expected 6 at cycle 11", got_q.size() - g0, lc);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc - c0 != 12) begin
            failures++;
            $display("FAIL stall_done: got %0d pulses at cycle %0d expected 1 at cycle 12", done_cnt - d0, done_cyc - c0);
        end
    endtask

    task automatic test_zero_and_ignored_start();
        int g0;
        int d0;
        int r0;
        int v0;
        step();
        r0 = re_cnt;
        v0 = valid_cnt;
        d0 = done_cnt;
        base_addr = 10'h0AA;
        num_words = 11'd0;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: done=%0b busy=%0b expected 1 0", done, busy);
        end
        repeat (4) step();
        checks++;
        if (re_cnt != r0 || valid_cnt != v0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_quiet: reads %0d valids %0d dones %0d expected 0 0 1",
                     re_cnt - r0, valid_cnt - v0, done_cnt - d0);
        end
        g0 = got_q.size();
        d0 = done_cnt;
        r0 = re_cnt;
        base_addr = 10'h100;
        num_words = 11'd6;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        base_addr = 10'h200;
        num_words = 11'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30 && done_cnt == d0; i++) step();
        repeat (4) step();
        checks++;
        if (got_q.size() - g0 != 6 || re_cnt - r0 != 6 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL ignored_start_counts: beats %0d reads %0d dones %0d expected 6 6 1",
                     got_q.size() - g0, re_cnt - r0, done_cnt - d0);
        end
        for (int i = 0; i < 6; i++) begin
            logic [DW-1:0] a;
            a = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            checks++;
            if (a !== DW'(32'h100 + i)) begin
                failures++;
                $display("FAIL ignored_start_beat[%0d]: got %h expected %h", i, a, DW'(32'h100 + i));
            end
        end
    endtask

    task automatic test_abort();
        int g0;
        int d0;
        int c0;
        g0 = got_q.size();
        d0 = done_cnt;
        step();
        base_addr = 10'h040;
        num_words = 11'd10;
        out_ready = 1'b1;
        start     = 1'b1;
        c0        = cyc;
        step();
        start = 1'b0;
        repeat (3) step();
        step();
        abort     = 1'b1;
        out_ready = 1'b0;
        #1;
        checks++;
        if (mem_re !== 1'b0 || busy !== 1'b1 || cyc - c0 != 5) begin
            failures++;
            $display("FAIL abort_re_drop: mem_re=%0b busy=%0b cycle=%0d expected 0 1 5", mem_re, busy, cyc - c0);
        end
        step();
        abort     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL abort_next: valid=%0b done=%0b busy=%0b state=%0d expected 0 1 0 0",
                     out_valid, done, busy, dbg_state);
        end
        repeat (3) step();
        checks++;
        if (got_q.size() - g0 != 2 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL abort_counts: beats %0d dones %0d expected 2 1", got_q.size() - g0, done_cnt - d0);
        end
        for (int i = 0; i < 2; i++) begin
            logic [DW-1:0] a;
            a = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            checks++;
            if (a !== DW'(32'h040 + i)) begin
                failures++;
                $display("FAIL abort_beat[%0d]: got %h expected %h", i, a, DW'(32'h040 + i));
            end
        end
        g0 = got_q.size();
        d0 = done_cnt;
        base_addr = 10'h050;
        num_words = 11'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 30 && done_cnt == d0; i++) step();
        step();
        checks++;
        if (got_q.size() - g0 != 2 ||
            (got_q.size() - g0 == 2 && (got_q[g0] !== DW'(32'h050) || got_q[g0 + 1] !== DW'(32'h051)))) begin
            failures++;
            $display("FAIL abort_followup: got %0d beats first %h expected 2 beats 050 051",
                     got_q.size() - g0, (got_q.size() > g0) ? got_q[g0] : DW'(0));
        end
    endtask

    task automatic test_reset_mid();
        int g0;
        step();
        base_addr = 10'h060;
        num_words = 11'd6;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_re, mem_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: mem_re=%0b addr=%h valid=%0b data=%h last=%0b busy=%0b done=%0b, expected all 0",
                     mem_re, mem_addr, out_valid, out_data, out_last, busy, done);
        end
        g0 = got_q.size();
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || got_q.size() != g0 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_idle: busy=%0b new beats %0d state=%0d expected 0 0 0",
                     busy, got_q.size() - g0, dbg_state);
        end
    endtask

`ifdef SV_FETCH_LOOP_EN
    task automatic test_loop();
        int g0;
        int d0;
        int c0;
        g0 = got_q.size();
        d0 = done_cnt;
        step();
        base_addr = 10'd5;
        num_words = 11'd3;
        loop_mode = 1'b1;
        out_ready = 1'b1;
        start     = 1'b1;
        c0        = cyc;
        step();
        start     = 1'b0;
        loop_mode = 1'b0;
        repeat (10) step();
        checks++;
        if (busy !== 1'b1 || done_cnt != d0) begin
            failures++;
            $display("FAIL loop_running: busy=%0b dones %0d expected 1 0", busy, done_cnt - d0);
        end
        step();
        abort     = 1'b1;
        out_ready = 1'b0;
        step();
        abort     = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL loop_abort: done=%0b busy=%0b valid=%0b expected 1 0 0", done, busy, out_valid);
        end
        step();
        checks++;
        if (got_q.size() - g0 != 9) begin
            failures++;
            $display("FAIL loop_beat_count: got %0d expected 9", got_q.size() - g0);
        end
        for (int i = 0; i < 9; i++) begin
            logic [DW:0] a;
            int          ac;
            a  = (g0 + i < got_q.size()) ? {got_last_q[g0 + i], got_q[g0 + i]} : 'x;
            ac = (g0 + i < got_cyc_q.size()) ? got_cyc_q[g0 + i] - c0 : -1;
            checks++;
            if (a !== {((i % 3) == 2), DW'(5 + (i % 3))} || ac != 3 + i) begin
                failures++;
                $display("FAIL loop_beat[%0d]: got last/data %h at cycle %0d expected %h at cycle %0d",
                         i, a, ac, {((i % 3) == 2), DW'(5 + (i % 3))}, 3 + i);
            end
        end
    endtask
`endif

    // Watchdog so the bench always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure_stall();
        test_stall_timing();
        test_zero_and_ignored_start();
        test_abort();
        test_reset_mid();
`ifdef SV_FETCH_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
